// File: rtl/maq_troco_if.sv
// maq_troco_if: sale/ejector signal bundle for the change-dispensing stage.
//   vendeu, saldo       sale strobe and credit from maq_venda
//   ej_ready            coin ejector can accept a coin this cycle
//   c5, c10, c20        coin eject commands (at most one high)
//   busy, done, erro    status: not idle, payout-finished pulse, sticky error
//   total_troco         cumulative paid change (only with TROCO_COUNT_EN)
// Modports: slave = the dispenser, master = its environment.
// Optional feature macro: TROCO_COUNT_EN.
interface maq_troco_if #(
   parameter int unsigned W = 7
);
   logic         vendeu;
   logic [W-1:0] saldo;
   logic         ej_ready;
   logic         c5;
   logic         c10;
   logic         c20;
   logic         busy;
   logic         done;
   logic         erro;
`ifdef TROCO_COUNT_EN
   logic [15:0]  total_troco;

   modport slave (
      input  vendeu, saldo, ej_ready,
      output c5, c10, c20, busy, done, erro, total_troco
   );
   modport master (
      output vendeu, saldo, ej_ready,
      input  c5, c10, c20, busy, done, erro, total_troco
   );
`else
   modport slave (
      input  vendeu, saldo, ej_ready,
      output c5, c10, c20, busy, done, erro
   );
   modport master (
      output vendeu, saldo, ej_ready,
      input  c5, c10, c20, busy, done, erro
   );
`endif
endinterface

// File: rtl/maq_troco.sv
// maq_troco: latches the credit on a sale strobe, subtracts PRICE and pays the
// remainder as a sequence of 20/10/5 coin-eject commands, each handshaked
// with the ejector. Ends with a one-cycle done pulse; erro flags short credit
// or a remainder that cannot be paid exactly.
// Ports:
//   clk   system clock, rising edge
//   res   asynchronous active-low reset
//   bus   maq_troco_if slave modport (vendeu/saldo/ej_ready in,
//         c5/c10/c20/busy/done/erro out, total_troco out when enabled)
// Optional feature macro: TROCO_COUNT_EN adds the saturating 16-bit
// cumulative change counter total_troco.
module maq_troco #(
   parameter int unsigned PRICE = 40,
   parameter int unsigned W     = 7
) (
   input  logic       clk,
   input  logic       res,
   maq_troco_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StEject, StDone} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] resto_q, resto_d;
   logic         c5_q, c5_d;
   logic         c10_q, c10_d;
   logic         c20_q, c20_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         erro_q, erro_d;
   logic [4:0]   coin;
   logic         xfer;

`ifdef TROCO_COUNT_EN
   logic [15:0]  total_q, total_d;
   logic [16:0]  total_sum;
`endif

   // Value of the coin currently being commanded (registered one-hot).
   always_comb begin
      coin = 5'd0;
      unique case ({c20_q, c10_q, c5_q})
         3'b100:  coin = 5'd20;
         3'b010:  coin = 5'd10;
         3'b001:  coin = 5'd5;
         default: coin = 5'd0;
      endcase
   end

   assign xfer = (state_q == StEject) && bus.ej_ready;

   always_comb begin
      state_d = state_q;
      resto_d = resto_q;
      c5_d    = c5_q;
      c10_d   = c10_q;
      c20_d   = c20_q;
      erro_d  = erro_q;
      unique case (state_q)
         StIdle: begin
            if (bus.vendeu) begin
               if (bus.saldo < W'(PRICE)) begin
                  erro_d = 1'b1;
               end else begin
                  resto_d = bus.saldo - W'(PRICE);
                  erro_d  = 1'b0;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (resto_q == '0) begin
               state_d = StDone;
            end else if (resto_q >= W'(20)) begin
               c20_d   = 1'b1;
               state_d = StEject;
            end else if (resto_q >= W'(10)) begin
               c10_d   = 1'b1;
               state_d = StEject;
            end else if (resto_q >= W'(5)) begin
               c5_d    = 1'b1;
               state_d = StEject;
            end else begin
               // Less than the smallest coin: unpayable, drop it.
               erro_d  = 1'b1;
               resto_d = '0;
               state_d = StDone;
            end
         end
         StEject: begin
            if (bus.ej_ready) begin
               resto_d = resto_q - W'(coin);
               c5_d    = 1'b0;
               c10_d   = 1'b0;
               c20_d   = 1'b0;
               state_d = StCalc;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Status outputs are registered from the next state.
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

`ifdef TROCO_COUNT_EN
   always_comb begin
      total_sum = {1'b0, total_q} + {12'd0, coin};
      total_d   = total_q;
      if (xfer) begin
         total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign bus.total_troco = total_q;
`endif

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= StIdle;
         resto_q <= '0;
         c5_q    <= 1'b0;
         c10_q   <= 1'b0;
         c20_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         resto_q <= resto_d;
         c5_q    <= c5_d;
         c10_q   <= c10_d;
         c20_q   <= c20_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         erro_q  <= erro_d;
      end
   end

   assign bus.c5   = c5_q;
   assign bus.c10  = c10_q;
   assign bus.c20  = c20_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.erro = erro_q;

endmodule
